bcd_convert_controller: RTL and testbench

BCD_CONVERT_CONTROLLER -- requirements
Module: bcd_convert_controller

---
 rtl/bcd_convert_controller.sv | 122 ++++++++++++
 tb/tb_bcd_convert_controller.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_convert_controller.sv
// Sequential BCD <-> excess-3 word converter: one digit per cycle through a
// single shared 4-bit converter, with an OR-accumulated invalid-digit flag.
module bcd_convert_controller #(
  parameter int NDIGITS = 4
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   START,
  input  logic                   MODE,
  input  logic [4*NDIGITS-1:0]   DIN,
  output logic [4*NDIGITS-1:0]   DOUT,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   ERR
);

  localparam int W  = 4 * NDIGITS;
  localparam int IW = $clog2(NDIGITS) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_FIN} state_t;

  state_t         r_state;
  state_t         w_next;
  logic [IW-1:0]  r_idx;
  logic [W-1:0]   r_din;
  logic [W-1:0]   r_res;
  logic [W-1:0]   r_dout;
  logic           r_mode;
  logic           r_werr;
  logic           r_err;

  logic [3:0]     w_digit;
  logic [3:0]     w_conv;
  logic           w_bad;
  logic           w_last;
  logic [W-1:0]   w_resNext;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (START)  w_next = S_CONV;
      S_CONV:  if (w_last) w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_last = (r_idx == IW'(NDIGITS - 1));

  always_comb begin
    w_digit = 4'h0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (r_idx == IW'(i)) w_digit = r_din[4*i +: 4];
    end
  end

  // Invalid digits map to 4'hF and raise w_bad; arithmetic wraps mod 16.
  always_comb begin
    w_conv = 4'hF;
    w_bad  = 1'b0;
    if (!r_mode) begin
      if (w_digit <= 4'd9) w_conv = w_digit + 4'd3;
      else                 w_bad  = 1'b1;
    end else begin
      if (w_digit >= 4'd3 && w_digit <= 4'd12) w_conv = w_digit - 4'd3;
      else                                      w_bad  = 1'b1;
    end
  end

  always_comb begin
    w_resNext = r_res;
    for (int i = 0; i < NDIGITS; i++) begin
      if (r_idx == IW'(i)) w_resNext[4*i +: 4] = w_conv;
    end
  end

  // DOUT/ERR only change on the final digit, so they hold during a conversion.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_idx  <= '0;
      r_din  <= '0;
      r_res  <= '0;
      r_mode <= 1'b0;
      r_werr <= 1'b0;
      r_dout <= '0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_din  <= DIN;
            r_mode <= MODE;
            r_idx  <= '0;
            r_res  <= '0;
            r_werr <= 1'b0;
          end
        end
        S_CONV: begin
          r_res  <= w_resNext;
          r_werr <= r_werr | w_bad;
          r_idx  <= r_idx + IW'(1);
          if (w_last) begin
            r_dout <= w_resNext;
            r_err  <= r_werr | w_bad;
          end
        end
        default: ;
      endcase
    end
  end

  assign DOUT = r_dout;
  assign ERR  = r_err;
  assign BUSY = (r_state == S_CONV);
  assign DONE = (r_state == S_FIN);

endmodule

// File: tb/tb_bcd_convert_controller.sv
// Scoreboard bench for bcd_convert_controller: stimulus pushes expected results,
// a monitor pops and compares them whenever DONE is seen.
module tb_bcd_convert_controller;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         START;
  logic         MODE;
  logic [W-1:0] DIN;
  logic [W-1:0] DOUT;
  logic         BUSY;
  logic         DONE;
  logic         ERR;

  typedef struct packed {
    logic [W-1:0] dout;
    logic         err;
  } exp_t;

  exp_t         expQ[$];
  exp_t         monExp;
  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] lastDout;
  logic         lastErr;

  bcd_convert_controller #(.NDIGITS(N)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .START (START),
    .MODE  (MODE),
    .DIN   (DIN),
    .DOUT  (DOUT),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .ERR   (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] d, input logic e);
    exp_t r;
    r.dout = d;
    r.err  = e;
    return r;
  endfunction

  // Reference: per-digit table lookup by plain arithmetic on integers.
  function automatic exp_t refModel(input logic mode, input logic [W-1:0] din);
    exp_t r;
    int   d;
    r.dout = '0;
    r.err  = 1'b0;
    for (int i = 0; i < N; i++) begin
      d = int'(din[4*i +: 4]);
      if (mode == 1'b0) begin
        if (d < 10) r.dout[4*i +: 4] = 4'(d + 3);
        else begin r.dout[4*i +: 4] = 4'hF; r.err = 1'b1; end
      end else begin
        if (d >= 3 && d <= 12) r.dout[4*i +: 4] = 4'(d - 3);
        else begin r.dout[4*i +: 4] = 4'hF; r.err = 1'b1; end
      end
    end
    return r;
  endfunction

  always @(negedge CLK) begin
    if (RST_N && DONE) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpectedDone actual=1 required=0");
      end else begin
        monExp = expQ.pop_front();
        checkOutput("dout", DOUT, monExp.dout);
        checkOutput("err", ERR, monExp.err);
        lastDout = monExp.dout;
        lastErr  = monExp.err;
      end
    end
  end

  task automatic applyStimulus(input logic mode, input logic [W-1:0] din, input exp_t e);
    int busyCycles;
    int doneCycle;
    busyCycles = 0;
    doneCycle  = 0;
    @(negedge CLK);
    START = 1'b1;
    MODE  = mode;
    DIN   = din;
    expQ.push_back(e);
    @(posedge CLK);
    #1;
    START = 1'b0;
    MODE  = 1'($urandom);
    DIN   = W'($urandom);
    for (int k = 1; k <= 3 * N + 4 && doneCycle == 0; k++) begin
      @(negedge CLK);
      if (DONE) doneCycle = k;
      else begin
        if (BUSY) busyCycles++;
        checkOutput("holdDout", DOUT, lastDout);
        checkOutput("holdErr", ERR, lastErr);
      end
    end
    checkOutput("doneLatency", doneCycle, N + 1);
    checkOutput("busyCycles", busyCycles, N);
  endtask

  task automatic waitDone(input string name);
    int seen;
    seen = 0;
    for (int k = 0; k < 3 * N + 4 && seen == 0; k++) begin
      @(negedge CLK);
      if (DONE) seen = 1;
    end
    checkOutput(name, seen, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] din;
    int           pos;

    RST_N    = 1'b0;
    START    = 1'b0;
    MODE     = 1'b0;
    DIN      = '0;
    lastDout = '0;
    lastErr  = 1'b0;

    #3;
    checkOutput("rstDout", DOUT, 0);
    checkOutput("rstBusy", BUSY, 0);
    checkOutput("rstDone", DONE, 0);
    checkOutput("rstErr", ERR, 0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;

    applyStimulus(1'b0, 16'h1234, mk(16'h4567, 1'b0));
    applyStimulus(1'b0, 16'h9870, mk(16'hCBA3, 1'b0));
    applyStimulus(1'b0, 16'h12A4, mk(16'h45F7, 1'b1));
    applyStimulus(1'b1, 16'h4567, mk(16'h1234, 1'b0));
    applyStimulus(1'b1, 16'h0345, mk(16'hF012, 1'b1));

    // START held high: DIN changes mid-conversion, re-accept only after FIN.
    @(negedge CLK);
    START = 1'b1;
    MODE  = 1'b0;
    DIN   = 16'h0918;
    expQ.push_back(refModel(1'b0, 16'h0918));
    @(posedge CLK);
    #1;
    MODE = 1'b1;
    DIN  = 16'hC3B7;
    expQ.push_back(refModel(1'b1, 16'hC3B7));
    waitDone("b2bDone1");
    @(negedge CLK);
    checkOutput("b2bIdleGap", BUSY, 0);
    @(negedge CLK);
    checkOutput("b2bReaccept", BUSY, 1);
    START = 1'b0;
    DIN   = W'($urandom);
    waitDone("b2bDone2");

    // Reset in the second CONV cycle discards the conversion.
    @(negedge CLK);
    START = 1'b1;
    MODE  = 1'b0;
    DIN   = 16'h5678;
    expQ.push_back(refModel(1'b0, 16'h5678));
    @(posedge CLK);
    #1;
    START = 1'b0;
    @(posedge CLK);
    #2;
    RST_N = 1'b0;
    void'(expQ.pop_back());
    #1;
    checkOutput("midRstDout", DOUT, 0);
    checkOutput("midRstBusy", BUSY, 0);
    checkOutput("midRstDone", DONE, 0);
    checkOutput("midRstErr", ERR, 0);
    lastDout = '0;
    lastErr  = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (8) @(negedge CLK);
    checkOutput("postRstBusy", BUSY, 0);
    applyStimulus(1'b0, 16'h0000, mk(16'h3333, 1'b0));

    for (int m = 0; m < 2; m++) begin
      for (int v = 0; v < 16; v++) begin
        pos = $urandom_range(0, N - 1);
        din = W'($urandom);
        din[4*pos +: 4] = 4'(v);
        applyStimulus(1'(m), din, refModel(1'(m), din));
      end
    end

    for (int t = 0; t < 30; t++) begin
      din = W'($urandom);
      MODE = 1'($urandom);
      applyStimulus(MODE, din, refModel(MODE, din));
    end

    repeat (3) @(negedge CLK);
    checkOutput("queueDrained", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
